mcc_sequencer: RTL and testbench

Parametrised multi-cycle successor to the single-cycle core top. It sequences fetch, decode, execute, memory and writeback over several cycles, so instruction and data memories may be slow, using req/ack handshakes. It owns the PC, the instruction register, the load-data register and the retired-instruction counter. Decode, register-file and execute logic sit beside it and are driven by its strobes.

---
 rtl/mcc_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_mcc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with req/ack memory
// handshakes, a per-request wait timeout and a retired-instruction counter.
module mcc_sequencer #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              id_valid,
  output logic              ex_en,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] mdr,
  output logic              rf_we,
  output logic              w_select,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic              fault
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] LP_TMO_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   r_mdr;
  logic [CNT_W-1:0]    r_retired;
  logic [WAIT_W-1:0]   r_wait;
  logic [ADDR_W-1:0]   r_br_target;
  logic                r_is_load;
  logic                r_is_store;
  logic                r_br_taken;
  logic                r_imem_req;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic                r_id_valid;
  logic                r_ex_en;
  logic                r_rf_we;
  logic                r_w_select;
  logic                r_halted;
  logic                r_fault;

  logic [ADDR_W-1:0]   w_pc_next;
  logic                w_timeout;

  assign w_pc_next = r_br_taken ? r_br_target : (r_pc + ADDR_W'(PC_STEP));
  // The last permitted wait cycle without an ack trips the fault; an ack in that cycle wins.
  assign w_timeout = (TIMEOUT != 0) && (r_wait == LP_TMO_LAST);

  // Sequencer state, datapath registers and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_mdr       <= '0;
      r_retired   <= '0;
      r_wait      <= '0;
      r_br_target <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_br_taken  <= 1'b0;
      r_imem_req  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_id_valid  <= 1'b0;
      r_ex_en     <= 1'b0;
      r_rf_we     <= 1'b0;
      r_w_select  <= 1'b0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_id_valid <= 1'b0;
      r_ex_en    <= 1'b0;
      r_rf_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run_en) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_imem_req <= 1'b0;
            r_id_valid <= 1'b1;
            r_state    <= S_DECODE;
          end else if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_ex_en <= 1'b1;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          // A word flagged as both load and store is handled as a load.
          r_is_load   <= is_load;
          r_is_store  <= is_store & ~is_load;
          r_br_taken  <= br_taken;
          r_br_target <= br_target;
          if (halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (is_load || is_store) begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= is_store & ~is_load;
            r_wait     <= '0;
            r_state    <= S_MEM;
          end else begin
            r_rf_we    <= 1'b1;
            r_w_select <= 1'b0;
            r_state    <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (r_is_load) begin
              r_mdr <= dmem_rdata;
            end
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= ~r_is_store;
            r_w_select <= r_is_load;
            r_state    <= S_WB;
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_pc       <= w_pc_next;
          r_retired  <= r_retired + CNT_W'(1);
          r_w_select <= 1'b0;
          if (run_en) begin
            r_imem_req <= 1'b1;
            r_wait     <= '0;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_fault    <= 1'b1;
          r_state    <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign id_valid  = r_id_valid;
  assign ex_en     = r_ex_en;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign mdr       = r_mdr;
  assign rf_we     = r_rf_we;
  assign w_select  = r_w_select;
  assign pc        = r_pc;
  assign retired   = r_retired;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule

// File: tb/tb_mcc_sequencer.sv
// Directed bench for mcc_sequencer: instruction table plus hand-written
// sequences for timeout, halt, run_en gating and reset corners.
module tb_mcc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic        imem_ack, dmem_ack;
  logic [31:0] imem_rdata, dmem_rdata, br_target;
  logic        is_load, is_store, br_taken, halt;

  logic        imem_req, id_valid, ex_en, dmem_req, dmem_we, rf_we, w_select, halted, fault;
  logic [31:0] imem_addr, instr, mdr, pc;
  logic [15:0] retired;

  logic        c4_imem_req, c4_id_valid, c4_ex_en, c4_dmem_req, c4_dmem_we;
  logic        c4_rf_we, c4_w_select, c4_halted, c4_fault;
  logic [31:0] c4_imem_addr, c4_instr, c4_mdr, c4_pc;
  logic [3:0]  c4_retired;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mcc_sequencer u_dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .id_valid(id_valid), .ex_en(ex_en),
    .is_load(is_load), .is_store(is_store), .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mdr(mdr), .rf_we(rf_we), .w_select(w_select), .pc(pc), .retired(retired),
    .halted(halted), .fault(fault)
  );

  mcc_sequencer #(.CNT_W(4), .RESET_PC(32'hFFFF_FFFC)) u_c4 (
    .clk(clk), .reset(reset), .run_en(run_en),
    .imem_req(c4_imem_req), .imem_addr(c4_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(c4_instr), .id_valid(c4_id_valid), .ex_en(c4_ex_en),
    .is_load(is_load), .is_store(is_store), .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .dmem_req(c4_dmem_req), .dmem_we(c4_dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mdr(c4_mdr), .rf_we(c4_rf_we), .w_select(c4_w_select), .pc(c4_pc), .retired(c4_retired),
    .halted(c4_halted), .fault(c4_fault)
  );

  typedef struct {
    logic [31:0] instr;
    logic        ld, st, bt;
    logic [31:0] tgt;
    logic        hlt;
    logic [31:0] rdata;
    int          dly;
    int          exp_cyc;
    logic        exp_rf, exp_ws, exp_we;
    logic [31:0] exp_pc, exp_mdr;
  } vec_t;

  vec_t vt[8];
  vec_t v_alu, v_halt;

  int   obs_cyc, obs_id, obs_ex;
  logic obs_rf, obs_ws, obs_we, obs_dreq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the first sample after WB (or halt).
  task automatic run_instr(input vec_t v);
    logic [15:0] r0;
    int          dcnt;
    logic        done;
    r0 = retired; dcnt = 0; done = 1'b0;
    obs_cyc = 0; obs_id = 0; obs_ex = 0;
    obs_rf = 1'b0; obs_ws = 1'b0; obs_we = 1'b0; obs_dreq = 1'b0;
    is_load = v.ld; is_store = v.st; br_taken = v.bt; br_target = v.tgt; halt = v.hlt;
    imem_rdata = v.instr; dmem_rdata = v.rdata;
    for (int k = 0; k < 60; k++) begin
      if (retired != r0 || halted || fault) begin
        done = 1'b1;
        break;
      end
      obs_cyc++;
      if (id_valid) obs_id = obs_cyc;
      if (ex_en) obs_ex = obs_cyc;
      if (rf_we) begin obs_rf = 1'b1; obs_ws = w_select; end
      if (dmem_req) begin obs_dreq = 1'b1; obs_we = dmem_we; dcnt++; end
      imem_ack = imem_req;
      dmem_ack = dmem_req && (dcnt == v.dly + 1);
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("instr_done_bound", {63'd0, done}, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc, 64'd0);
    chk({tag, "_instr"}, instr, 64'd0);
    chk({tag, "_mdr"}, mdr, 64'd0);
    chk({tag, "_retired"}, retired, 64'd0);
    chk({tag, "_flags"}, {halted, fault, imem_req, dmem_req, id_valid, ex_en, rf_we, dmem_we}, 64'd0);
  endtask

  int   cnt, idle_req;
  logic seen;

  initial begin
    //        instr          ld    st    bt    tgt            hlt   rdata          dly cyc rf    ws    we    pc             mdr
    vt[0] = '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 4, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000};
    vt[1] = '{32'h0000_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 3, 8, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF};
    vt[2] = '{32'h0000_0023, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h1111_1111, 0, 5, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF};
    vt[3] = '{32'h0000_0063, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 0, 4, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF};
    vt[4] = '{32'h0000_0013, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1, 6, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'hCAFE_F00D};
    vt[5] = '{32'h0000_0067, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 0, 4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D};
    vt[6] = '{32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 4, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hCAFE_F00D};
    vt[7] = '{32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0000, 0, 4, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'hCAFE_F00D};
    v_alu  = '{32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 0, 4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    v_halt = '{32'h0000_0073, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0, 0, 3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    reset = 1'b0; run_en = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'h0; dmem_rdata = 32'h0; br_target = 32'h0;
    is_load = 1'b0; is_store = 1'b0; br_taken = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {63'd0, imem_req}, 64'd0);
    run_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_instr(vt[i]);
      chk($sformatf("v%0d_cycles", i), obs_cyc, vt[i].exp_cyc);
      chk($sformatf("v%0d_id_ex", i), {obs_id[15:0], obs_ex[15:0]}, {16'd2, 16'd3});
      chk($sformatf("v%0d_rf_ws_we", i), {obs_rf, obs_ws, obs_we}, {vt[i].exp_rf, vt[i].exp_ws, vt[i].exp_we});
      chk($sformatf("v%0d_pc", i), pc, vt[i].exp_pc);
      chk($sformatf("v%0d_mdr", i), mdr, vt[i].exp_mdr);
      chk($sformatf("v%0d_instr", i), instr, vt[i].instr);
      chk($sformatf("v%0d_retired", i), retired, i + 1);
      if (i == 0) chk("c4_pc_wrap", c4_pc, 64'd0);
    end

    for (int i = 0; i < 8; i++) run_instr(v_alu);
    chk("retired_16", retired, 64'd16);
    chk("c4_retired_wrap", c4_retired, 64'd0);
    chk("pc_after_16", pc, 64'h24);

    run_en = 1'b0;
    run_instr(v_alu);
    idle_req = 0;
    for (int k = 0; k < 5; k++) begin
      if (imem_req) idle_req++;
      @(negedge clk);
    end
    chk("run_en_off_no_req", idle_req, 64'd0);
    run_en = 1'b1;
    @(negedge clk);
    chk("run_en_on_req", {63'd0, imem_req}, 64'd1);

    run_instr(v_halt);
    chk("halt_cycles", obs_cyc, 64'd3);
    chk("halt_flags", {halted, fault, obs_dreq, obs_rf}, {1'b1, 1'b0, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    chk("halt_pc", pc, 64'h28);
    chk("halt_retired", retired, 64'd17);
    chk("halt_quiet", {halted, imem_req, dmem_req}, {1'b1, 1'b0, 1'b0});

    reset = 1'b0;
    #1;
    check_reset_values("rst2");
    halt = 1'b0; is_load = 1'b0; is_store = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fetch with no ack: fault after the 15th request cycle.
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (fault) break;
      if (imem_req) cnt++;
      imem_ack = 1'b0;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cnt, 64'd15);
    chk("tmo_fault", {fault, imem_req}, {1'b1, 1'b0});
    repeat (3) @(negedge clk);
    chk("fault_frozen", {pc, retired, 15'd0, fault}, {32'd0, 16'd0, 15'd0, 1'b1});

    reset = 1'b0;
    #1;
    chk("fault_cleared", {63'd0, fault}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Ack in exactly the 15th request cycle completes the fetch.
    imem_rdata = 32'hA5A5_0F0F;
    cnt = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (fault || id_valid) begin seen = id_valid; break; end
      if (imem_req) cnt++;
      imem_ack = imem_req && (cnt == 15);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("ack15_cycles", cnt, 64'd15);
    chk("ack15_no_fault", {fault, seen}, {1'b0, 1'b1});
    chk("ack15_instr", instr, 64'hA5A5_0F0F);

    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req && retired == 16'd1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("ack15_retired", {retired, 15'd0, seen}, {16'd1, 15'd0, 1'b1});
    reset = 1'b0;
    #1;
    chk("rst_drops_req", {63'd0, imem_req}, 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD; run_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ack_ignored", {instr, 30'd0, id_valid, imem_req}, 64'd0);
    imem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
